k_smallest_tracker: RTL
=======================

// Module: k_smallest_tracker
// PURPOSE
//  Streaming stage directly upstream of group_decider in the KNN accelerator.
//  Consumes one (distance, group-bit) sample per cycle for one query vector.
//  Keeps a sorted list of the K smallest distances seen, each with its group bit.
//  After the query's last sample, presents the K group bits (feeds
//  group_decider.i_5_smallest_distances_group_bit) and pulses o_done.
// PARAMETERS
//  DIST_W  16  width of an unsigned distance sample
//  K       5   list depth; must be 5 to match group_decider
//  CNT_W   3   width of o_count, equals $clog2(K+1)
// PORTS
//  clk                              in   1        single clock, rising edge
//  rst                              in   1        asynchronous, active-high reset
//  i_start                          in   1        clear list and open a new query
//  i_valid                          in   1        sample valid
//  i_distance                       in   DIST_W   unsigned distance of the sample
//  i_group                          in   1        group bit of the sample
//  i_last                           in   1        qualifies i_valid; last sample of query
//  o_ready                          out  1        high only in COLLECT
//  o_5_smallest_distances_group_bit out  K        bit i = group of i-th smallest (bit0 = nearest)
//  o_smallest_distances             out  K*DIST_W slice i = i-th smallest distance
//  o_count                          out  CNT_W    number of occupied slots, 0..K
//  o_done                           out  1        single-cycle pulse, list final
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; all slots empty.
//  Reset values: distance=0, group=0, o_count=0, o_done=0, o_ready=0.
//  FSM: IDLE -(i_start)-> COLLECT -(accepted i_last)-> DONE -(1 cycle)-> IDLE.
//  i_start in any state: clear all slots, o_count=0, go to COLLECT next cycle.
//  i_start has priority: a sample valid in the same cycle is discarded.
//  Accept = i_valid & o_ready; throughput 1 sample/cycle, no stalls in COLLECT.
//  i_valid outside COLLECT is ignored.
//  Insertion is single-cycle, parallel compare-and-shift.
//   Each slot has its own occupied bit; an empty slot accepts any distance.
//   Empty slots accept even 2^DIST_W-1.
//   Insert position = first slot whose distance > i_distance, or first empty slot.
//   Slots at and after the insert position shift up by one; slot K-1 falls off.
//   Ties: a new sample goes after existing equal distances (earliest arrival wins).
//   List full and i_distance >= slot K-1: sample dropped, list unchanged.
//  o_count increments per accepted sample and saturates at K.
//  Latency: a sample accepted at edge N is reflected in the outputs after edge N.
//  o_done is high in the cycle after the edge accepting i_last (DONE state).
//  Outputs hold their final values after DONE until the next i_start or rst.
//  Fewer than K samples: unused slots read distance=0, group=0; o_count gives valid depth.
//  Distances compare as unsigned; no arithmetic beyond compare.
//  rst mid-query: immediate return to the reset values; partial list lost.
// TESTING
//  1 Reset during COLLECT with 3 samples held -> all outputs 0 at once, o_ready=0.
//  2 Stream d=50,10,40,20,30,5,60 with g=1,0,1,0,1,1,0, last on 60:
//    -> distances 5,10,20,30,40; group bits 5'b11001; o_count=5; o_done one cycle.
//  3 Six samples d=7 with g=1,0,0,0,0,1 -> group bits 5'b00001; sixth sample dropped.
//  4 Three samples 9/g1, 3/g0, 6/g1, last on 6:
//    -> distances 3,6,9,0,0; group bits 5'b00110; o_count=3.
//  5 32 back-to-back samples d=31..0 plus first-sample d=16'hFFFF on a new query:
//    -> list 0..4 after the 32; 0xFFFF stored in slot 0 of the new query.
//  6 i_start with i_valid in COLLECT, 2 samples held:
//    -> list cleared, o_count=0, that sample not stored.

Source files
------------

// File: rtl/k_smallest_tracker.sv
// Keeps the K smallest (distance, group) samples of one query in sorted order.
// Latency: a sample accepted at edge N is visible in the outputs right after edge N.
// Backpressure: o_ready is high throughout COLLECT and low in every other state.
module k_smallest_tracker #(
   parameter int DIST_W = 16,
   parameter int K      = 5,
   parameter int CNT_W  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_start,
   input  logic                i_valid,
   input  logic [DIST_W-1:0]   i_distance,
   input  logic                i_group,
   input  logic                i_last,
   output logic                o_ready,
   output logic [K-1:0]        o_5_smallest_distances_group_bit,
   output logic [K*DIST_W-1:0] o_smallest_distances,
   output logic [CNT_W-1:0]    o_count,
   output logic                o_done
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t state_q, state_nxt;

   logic [DIST_W-1:0] dist_q [K];
   logic [DIST_W-1:0] dist_d [K];
   logic [K-1:0]      grp_q, grp_d;
   logic [K-1:0]      occ_q, occ_d;
   logic [CNT_W-1:0]  count_q;

   // gt[i]: slot i would yield its place to the new sample (empty, or strictly larger).
   // Because the list is sorted and filled from slot 0, gt is monotonic over i.
   logic [K-1:0] gt;
   logic [K-1:0] ins_here;
   logic         accept;

   // i_start wins over a sample presented in the same cycle
   assign accept = i_valid & o_ready & ~i_start;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_nxt;
   end

   // Next-state logic; i_start restarts the query from any state
   always_comb begin
      state_nxt = state_q;
      if (i_start) begin
         state_nxt = S_COLLECT;
      end else begin
         case (state_q)
            S_IDLE:    state_nxt = S_IDLE;
            S_COLLECT: if (accept && i_last) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
         endcase
      end
   end

   // FSM outputs are pure functions of the state
   always_comb begin
      o_ready = (state_q == S_COLLECT);
      o_done  = (state_q == S_DONE);
   end

   // Parallel compare: ties compare as not-greater, so a new equal sample lands behind
   always_comb begin
      for (int i = 0; i < K; i++) begin
         gt[i] = ~occ_q[i] | (dist_q[i] > i_distance);
      end
      ins_here[0] = gt[0];
      for (int i = 1; i < K; i++) begin
         ins_here[i] = gt[i] & ~gt[i-1];
      end
   end

   // Shift network: insert point takes the sample, slots above take their lower neighbour
   always_comb begin
      for (int i = 0; i < K; i++) begin
         dist_d[i] = dist_q[i];
         grp_d[i]  = grp_q[i];
         occ_d[i]  = occ_q[i];
      end
      if (gt[0]) begin
         dist_d[0] = i_distance;
         grp_d[0]  = i_group;
         occ_d[0]  = 1'b1;
      end
      for (int i = 1; i < K; i++) begin
         if (ins_here[i]) begin
            dist_d[i] = i_distance;
            grp_d[i]  = i_group;
            occ_d[i]  = 1'b1;
         end else if (gt[i]) begin
            dist_d[i] = dist_q[i-1];
            grp_d[i]  = grp_q[i-1];
            occ_d[i]  = occ_q[i-1];
         end
      end
   end

   // Slot storage: cleared by reset or i_start, updated on each accepted sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < K; i++) dist_q[i] <= '0;
         grp_q <= '0;
         occ_q <= '0;
      end else if (i_start) begin
         for (int i = 0; i < K; i++) dist_q[i] <= '0;
         grp_q <= '0;
         occ_q <= '0;
      end else if (accept) begin
         for (int i = 0; i < K; i++) dist_q[i] <= dist_d[i];
         grp_q <= grp_d;
         occ_q <= occ_d;
      end
   end

   // Occupancy counter saturating at K
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (i_start) begin
         count_q <= '0;
      end else if (accept && (count_q != CNT_W'(K))) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   // Flatten the slot array onto the output bus, slot 0 in the low bits
   always_comb begin
      for (int i = 0; i < K; i++) begin
         o_smallest_distances[i*DIST_W +: DIST_W] = dist_q[i];
      end
      o_5_smallest_distances_group_bit = grp_q;
      o_count                          = count_q;
   end

endmodule
